// File: rtl/rs_pkg.sv
// Shared widths, tag constants and opcode encodings used by the register bank,
// CDB arbiter and reservation station.
package rs_pkg;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int OP_W   = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic {
    DISP_IDLE = 1'b0,
    DISP_HOLD = 1'b1
  } disp_state_e;
endpackage

// File: rtl/rs_entry.sv
// One station entry: holds op and two operands, snooping the CDB for
// outstanding producer tags (also at allocation time, as a same-cycle bypass).
module rs_entry
  import rs_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] vj_i,
  input  logic [TAG_W-1:0]  qj_i,
  input  logic [DATA_W-1:0] vk_i,
  input  logic [TAG_W-1:0]  qk_i,
  input  logic              clear_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [OP_W-1:0]   op_o,
  output logic [DATA_W-1:0] vj_o,
  output logic [DATA_W-1:0] vk_o
);
  logic              busy_q, busy_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
  logic              cdb_live;

  // TAG_NONE on the bus never matches, so a resolved operand cannot be overwritten.
  assign cdb_live = cdb_valid_i && (cdb_tag_i != TAG_NONE);

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    qj_d   = qj_q;
    vk_d   = vk_q;
    qk_d   = qk_q;
    if (flush_i) begin
      busy_d = 1'b0;
      qj_d   = TAG_NONE;
      qk_d   = TAG_NONE;
    end else if (alloc_i) begin
      busy_d = 1'b1;
      op_d   = op_i;
      if (cdb_live && cdb_tag_i == qj_i) begin
        vj_d = cdb_data_i;
        qj_d = TAG_NONE;
      end else begin
        vj_d = vj_i;
        qj_d = qj_i;
      end
      if (cdb_live && cdb_tag_i == qk_i) begin
        vk_d = cdb_data_i;
        qk_d = TAG_NONE;
      end else begin
        vk_d = vk_i;
        qk_d = qk_i;
      end
    end else begin
      if (clear_i) busy_d = 1'b0;
      if (busy_q && cdb_live && cdb_tag_i == qj_q) begin
        vj_d = cdb_data_i;
        qj_d = TAG_NONE;
      end
      if (busy_q && cdb_live && cdb_tag_i == qk_q) begin
        vk_d = cdb_data_i;
        qk_d = TAG_NONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      op_q   <= '0;
      vj_q   <= '0;
      qj_q   <= TAG_NONE;
      vk_q   <= '0;
      qk_q   <= TAG_NONE;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      vj_q   <= vj_d;
      qj_q   <= qj_d;
      vk_q   <= vk_d;
      qk_q   <= qk_d;
    end
  end

  assign busy_o  = busy_q;
  assign ready_o = busy_q && (qj_q == TAG_NONE) && (qk_q == TAG_NONE);
  assign op_o    = op_q;
  assign vj_o    = vj_q;
  assign vk_o    = vk_q;
endmodule

// File: rtl/reservation_station.sv
// Reservation station: lowest-free allocation, lowest-ready dispatch with a
// hold lock so an offer stays stable until the functional unit accepts it.
module reservation_station
  import rs_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int BASE_TAG = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [OP_W-1:0]   issue_op_i,
  input  logic [DATA_W-1:0] issue_vj_i,
  input  logic [DATA_W-1:0] issue_vk_i,
  input  logic [TAG_W-1:0]  issue_qj_i,
  input  logic [TAG_W-1:0]  issue_qk_i,
  output logic [TAG_W-1:0]  issue_tag_o,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_tag_i,
  input  logic [DATA_W-1:0] cdb_data_i,
  output logic              disp_valid_o,
  input  logic              disp_ready_i,
  output logic [OP_W-1:0]   disp_op_o,
  output logic [DATA_W-1:0] disp_a_o,
  output logic [DATA_W-1:0] disp_b_o,
  output logic [TAG_W-1:0]  disp_tag_o,
  output disp_state_e       dbg_disp_state_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy, ready, alloc, clear;
  logic [OP_W-1:0]   e_op [DEPTH];
  logic [DATA_W-1:0] e_vj [DEPTH];
  logic [DATA_W-1:0] e_vk [DEPTH];

  logic              free_found;
  logic [IDX_W-1:0]  free_idx, rdy_idx, sel, sel_q, sel_d;
  logic              disp_valid, issue_fire;
  disp_state_e       state_q, state_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign alloc[i] = issue_fire && (free_idx == IDX_W'(i));
    assign clear[i] = disp_valid && disp_ready_i && (sel == IDX_W'(i));
    rs_entry u_entry (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alloc_i     (alloc[i]),
      .op_i        (issue_op_i),
      .vj_i        (issue_vj_i),
      .qj_i        (issue_qj_i),
      .vk_i        (issue_vk_i),
      .qk_i        (issue_qk_i),
      .clear_i     (clear[i]),
      .cdb_valid_i (cdb_valid_i),
      .cdb_tag_i   (cdb_tag_i),
      .cdb_data_i  (cdb_data_i),
      .busy_o      (busy[i]),
      .ready_o     (ready[i]),
      .op_o        (e_op[i]),
      .vj_o        (e_vj[i]),
      .vk_o        (e_vk[i])
    );
  end

  // Downward scans leave the lowest matching index in place.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    rdy_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i]) rdy_idx = IDX_W'(i);
    end
  end

  assign issue_ready_o = free_found;
  assign issue_fire    = issue_valid_i && free_found && !flush_i;
  assign issue_tag_o   = free_found ? TAG_W'(BASE_TAG + int'(free_idx)) : TAG_NONE;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DISP_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (flush_i) begin
      state_d = DISP_IDLE;
    end else if (disp_valid && !disp_ready_i) begin
      state_d = DISP_HOLD;
      sel_d   = sel;
    end else begin
      state_d = DISP_IDLE;
    end
  end

  always_comb begin
    sel        = rdy_idx;
    disp_valid = |ready;
    if (state_q == DISP_HOLD) begin
      sel        = sel_q;
      disp_valid = ready[sel_q];
    end
  end

  assign disp_valid_o     = disp_valid;
  assign disp_op_o        = disp_valid ? e_op[sel] : '0;
  assign disp_a_o         = disp_valid ? e_vj[sel] : '0;
  assign disp_b_o         = disp_valid ? e_vk[sel] : '0;
  assign disp_tag_o       = disp_valid ? TAG_W'(BASE_TAG + int'(sel)) : TAG_NONE;
  assign dbg_disp_state_o = state_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station (DEPTH=3, BASE_TAG=1, tags 1..3).
module tb_reservation_station;
  import rs_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              issue_valid, issue_ready;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic [TAG_W-1:0]  issue_qj, issue_qk, issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              disp_valid, disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_a, disp_b;
  logic [TAG_W-1:0]  disp_tag;
  disp_state_e       dbg_state;

  int n_vec = 0;
  int n_err = 0;

  reservation_station #(.DEPTH(3), .BASE_TAG(1)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_op_i       (issue_op),
    .issue_vj_i       (issue_vj),
    .issue_vk_i       (issue_vk),
    .issue_qj_i       (issue_qj),
    .issue_qk_i       (issue_qk),
    .issue_tag_o      (issue_tag),
    .cdb_valid_i      (cdb_valid),
    .cdb_tag_i        (cdb_tag),
    .cdb_data_i       (cdb_data),
    .disp_valid_o     (disp_valid),
    .disp_ready_i     (disp_ready),
    .disp_op_o        (disp_op),
    .disp_a_o         (disp_a),
    .disp_b_o         (disp_b),
    .disp_tag_o       (disp_tag),
    .dbg_disp_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then release strobes; settle time follows the caller's drive.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    disp_ready  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_issue(input logic [2:0] op, input logic [15:0] vj, input logic [2:0] qj,
                             input logic [15:0] vk, input logic [2:0] qk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_qj    = qj;
    issue_vk    = vk;
    issue_qk    = qk;
  endtask

  task automatic drive_cdb(input logic [2:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
    issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; disp_ready = 1'b0;
    #3;
    check("rst_issue_ready", issue_ready, 1);
    check("rst_issue_tag", issue_tag, 1);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_tag", disp_tag, 0);
    check("rst_disp_a", disp_a, 0);
    #5 rst_n = 1'b1;
    tick();

    // basic issue with both operands present
    drive_issue(3'd1, 16'd5, 3'd0, 16'd7, 3'd0); settle();
    check("t1_issue_tag", issue_tag, 1);
    tick(); settle();
    check("t1_disp_valid", disp_valid, 1);
    check("t1_disp_a", disp_a, 5);
    check("t1_disp_b", disp_b, 7);
    check("t1_disp_tag", disp_tag, 1);
    check("t1_disp_op", disp_op, 1);
    disp_ready = 1'b1; tick(); settle();
    check("t1_after_disp", disp_valid, 0);

    // operand resolved by later CDB broadcast
    drive_issue(3'd2, 16'd0, 3'd4, 16'd3, 3'd0); tick(); settle();
    check("t2_wait", disp_valid, 0);
    drive_cdb(3'd4, 16'h00AA); settle();
    check("t2_bcast_cycle", disp_valid, 0);
    tick(); settle();
    check("t2_disp_valid", disp_valid, 1);
    check("t2_disp_a", disp_a, 16'h00AA);
    check("t2_disp_b", disp_b, 3);
    disp_ready = 1'b1; tick();

    // same-cycle bypass at issue
    drive_issue(3'd3, 16'd9, 3'd0, 16'd0, 3'd5); drive_cdb(3'd5, 16'h1234); tick(); settle();
    check("t3_disp_valid", disp_valid, 1);
    check("t3_disp_a", disp_a, 9);
    check("t3_disp_b", disp_b, 16'h1234);
    disp_ready = 1'b1; tick();

    // a tag-0 broadcast must not overwrite a present operand
    drive_issue(3'd4, 16'h0011, 3'd0, 16'h0022, 3'd6); tick();
    drive_cdb(3'd0, 16'hFFFF); tick(); settle();
    check("t0_no_ready", disp_valid, 0);
    drive_cdb(3'd6, 16'h0033); tick(); settle();
    check("t0_disp_a", disp_a, 16'h0011);
    check("t0_disp_b", disp_b, 16'h0033);
    disp_ready = 1'b1; tick();

    // fill, ignored fourth issue, free the middle entry
    settle();
    check("t4_tag0", issue_tag, 1);
    drive_issue(3'd1, 16'd0, 3'd7, 16'd1, 3'd0); tick(); settle();
    check("t4_tag1", issue_tag, 2);
    drive_issue(3'd2, 16'd0, 3'd6, 16'd2, 3'd0); tick(); settle();
    check("t4_tag2", issue_tag, 3);
    drive_issue(3'd3, 16'd0, 3'd5, 16'd3, 3'd0); tick(); settle();
    check("t4_full_ready", issue_ready, 0);
    check("t4_full_tag", issue_tag, 0);
    drive_issue(3'd7, 16'hDEAD, 3'd0, 16'hBEEF, 3'd0); tick(); settle();
    check("t4_ignored", disp_valid, 0);
    drive_cdb(3'd6, 16'h0066); tick(); settle();
    check("t4_disp_tag", disp_tag, 2);
    check("t4_disp_a", disp_a, 16'h0066);
    disp_ready = 1'b1; settle();
    check("t4_freeing_not_counted", issue_ready, 0);
    tick(); settle();
    check("t4_ready_after", issue_ready, 1);
    check("t4_tag_after", issue_tag, 2);
    check("t4_no_disp", disp_valid, 0);

    // offer held while a lower entry becomes ready
    drive_cdb(3'd5, 16'h0055); tick(); settle();
    check("t5_offer_tag", disp_tag, 3);
    drive_cdb(3'd7, 16'h0077); tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t5_hold_tag", disp_tag, 3);
      check("t5_hold_a", disp_a, 16'h0055);
      tick();
    end
    disp_ready = 1'b1;
    drive_issue(3'd5, 16'h0010, 3'd0, 16'h0020, 3'd0); settle();
    check("t5_issue_with_disp_tag", issue_tag, 2);
    tick(); settle();
    check("t5_next_tag", disp_tag, 1);
    check("t5_next_a", disp_a, 16'h0077);
    disp_ready = 1'b1; tick(); settle();
    check("t5_issued_tag", disp_tag, 2);
    check("t5_issued_a", disp_a, 16'h0010);
    disp_ready = 1'b1; tick(); settle();
    check("t5_empty", disp_valid, 0);
    check("t5_empty_tag", issue_tag, 1);

    // own-tag snoop
    drive_issue(3'd6, 16'd0, 3'd1, 16'd4, 3'd0); tick();
    drive_cdb(3'd1, 16'hBEEF); tick(); settle();
    check("t6_own_valid", disp_valid, 1);
    check("t6_own_a", disp_a, 16'hBEEF);

    // flush drops everything and the simultaneous issue
    flush = 1'b1;
    drive_issue(3'd1, 16'd1, 3'd0, 16'd1, 3'd0); tick(); settle();
    check("t7_flush_disp", disp_valid, 0);
    check("t7_flush_ready", issue_ready, 1);
    check("t7_flush_tag", issue_tag, 1);

    // asynchronous reset mid-operation
    drive_issue(3'd2, 16'd1, 3'd0, 16'd2, 3'd0); tick();
    drive_issue(3'd3, 16'd3, 3'd7, 16'd4, 3'd0); tick(); settle();
    check("t8_pre_valid", disp_valid, 1);
    check("t8_pre_tag", issue_tag, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_valid", disp_valid, 0);
    check("t8_async_ready", issue_ready, 1);
    check("t8_async_tag", issue_tag, 1);
    #1 rst_n = 1'b1;
    tick();
    drive_cdb(3'd7, 16'h0777); tick(); settle();
    check("t8_no_stale", disp_valid, 0);
    check("t8_tag_after", issue_tag, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 3: number of station entries.
REQ-002 Parameter BASE_TAG, default 1: tag of entry 0; entry i carries tag BASE_TAG+i; tag 0 means "value present".
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous clear of all entries.
REQ-006 issue_valid  input  1  issue request from decode.
REQ-007 issue_ready  output  1  at least one free entry.
REQ-008 issue_op  input  3  operation code.
REQ-009 issue_vj, issue_vk  input  16 each  operand values read from the register bank.
REQ-010 issue_qj, issue_qk  input  3 each  producer tags; 0 = matching v-input is valid.
REQ-011 issue_tag  output  3  tag of the entry the next accepted issue will occupy.
REQ-012 cdb_valid  input  1  CDB broadcast qualifier.
REQ-013 cdb_tag  input  3  tag being broadcast.
REQ-014 cdb_data  input  16  broadcast value.
REQ-015 disp_valid  output  1  a ready entry is offered to the functional unit.
REQ-016 disp_ready  input  1  functional unit accepts.
REQ-017 disp_op  output  3  opcode of offered entry.
REQ-018 disp_a, disp_b  output  16 each  operand values of offered entry.
REQ-019 disp_tag  output  3  tag of offered entry, which the unit later broadcasts on the CDB.

Function
REQ-020 Each entry SHALL hold busy, op, vj, qj, vk, qk.
REQ-021 issue_ready SHALL be 1 iff any entry is non-busy in the current state; an entry freed this cycle is not counted.
REQ-022 issue_tag SHALL equal BASE_TAG plus the lowest non-busy index; when no entry is free it SHALL equal 0.
REQ-023 On issue_valid&&issue_ready the lowest free entry SHALL be written and set busy at the next edge.
REQ-024 Same-cycle bypass: if cdb_valid and cdb_tag==issue_qj (nonzero), the entry SHALL store vj=cdb_data and qj=0; the same rule applies to qk.
REQ-025 Every busy entry with qj==cdb_tag (nonzero) and cdb_valid SHALL capture vj=cdb_data and qj=0 at the edge; the same rule applies to qk; both operands may capture in one cycle.
REQ-026 An entry SHALL be ready when busy && qj==0 && qk==0, evaluated on registered state; an entry that captures on the CDB SHALL be offered no earlier than the next cycle.
REQ-027 disp_valid SHALL be 1 iff any entry is ready; the lowest-index ready entry SHALL be selected.
REQ-028 While disp_valid=1 and disp_ready=0, the selection and all disp_* outputs SHALL hold stable, even if a lower-index entry becomes ready.
REQ-029 On disp_valid&&disp_ready the selected entry SHALL be cleared non-busy at the edge; the next offer is allowed the following cycle.
REQ-030 Issue and dispatch in the same cycle SHALL both complete; issue SHALL never target the entry being dispatched (REQ-021).
REQ-031 A cdb_tag equal to the tag of a station's own entry SHALL be snooped like any other tag.
REQ-032 flush=1 SHALL clear all busy bits at the edge, ignore the simultaneous issue, and drop disp_valid the next cycle.
REQ-033 cdb_tag==0 SHALL never cause a capture.

Reset
REQ-034 While reset=0, all busy bits, q fields and the dispatch lock SHALL be 0; issue_ready=1, issue_tag=BASE_TAG, disp_valid=0, and disp_op/disp_a/disp_b/disp_tag=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-036 A shared package SHALL hold the data width (16), tag width (3), opcode width (3), the TAG_NONE=0 constant and the opcode encodings, so the register bank, CDB arbiter and station use the same values.
REQ-037 The per-entry storage with CDB snoop SHALL be one sub-module, rs_entry, instantiated DEPTH times; allocation and dispatch priority logic SHALL stay in the parent.

Verification
REQ-038 After reset, issue op=1, vj=5, qj=0, vk=7, qk=0 -> issue_tag=1 at issue, then disp_valid=1 next cycle with disp_a=5, disp_b=7, disp_tag=1.
REQ-039 Issue qj=4, then cdb_valid=1 with cdb_tag=4, cdb_data=0x00AA -> disp_valid=1 one cycle after the broadcast, with disp_a=0x00AA.
REQ-040 Issue qk=5 in the same cycle as a CDB broadcast of tag 5, data 0x1234 -> entry stores vk=0x1234, and disp_valid=1 next cycle.
REQ-041 Fill 3 entries with unresolved tags -> issue_ready=0 and issue_tag=0; a fourth issue_valid is ignored; resolve entry 1 and dispatch it -> issue_ready=1 and issue_tag=2 the cycle after.
REQ-042 Entry 2 is offered and disp_ready=0 for 3 cycles while entry 0 becomes ready -> disp_tag holds 3; after the handshake, disp_tag=1.
REQ-043 Pulse reset low while 2 entries are busy and disp_valid=1 -> disp_valid=0 and issue_ready=1 asynchronously, and stale tags are not dispatched after release.
